// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed image over a byte stream
// (magic A5, 16-bit word count, little-endian payload words, 8-bit sum),
// writes each assembled word to program RAM and releases the CPU once
// the checksum matches. Any malformed or stalled frame parks in ERROR.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reload,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_wdata,
    output logic        prog_we,
    output logic        prog_loading_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [7:0] MAGIC = 8'hA5;

    // Idle counter is wide enough to hold TIMEOUT_CYCLES itself.
    localparam int unsigned        IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_e;

    // States in which a frame is in flight and the idle watchdog runs.
    function automatic logic in_frame(input state_e s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
    endfunction

    state_e              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [15:0]         word_idx_q, word_idx_d;
    // Only lanes 0..2 are stored; lane 3 is taken straight from rx_data
    // in the cycle the word completes.
    logic [23:0]         asm_q, asm_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [15:0]         words_loaded_q, words_loaded_d;
    logic [31:0]         prog_addr_q, prog_addr_d;
    logic [31:0]         prog_wdata_q, prog_wdata_d;
    logic                prog_we_q, prog_we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic        consume;
    logic        byte_last;
    logic        word_last;
    logic [15:0] len_full;
    logic        len_over;
    logic        timeout;

    assign consume   = rx_valid && rx_ready;
    assign byte_last = (byte_idx_q == 2'd3);
    assign word_last = ((word_idx_q + 16'd1) == len_q);
    assign len_full  = {rx_data, len_q[7:0]};
    assign len_over  = (32'(len_full) > MAX_WORDS);
    assign timeout   = in_frame(state_q) && !consume && (idle_cnt_q == IDLE_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: byte-driven transitions, then watchdog, then reload.
    always_comb begin
        // NOTE: the default assignment first means no path leaves state_d
        // unassigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (consume && (rx_data == MAGIC)) state_d = LEN0;
            end
            LEN0: begin
                if (consume) state_d = LEN1;
            end
            LEN1: begin
                if (consume) begin
                    if (len_over)              state_d = ERROR;
                    else if (len_full == 16'd0) state_d = CSUM;
                    else                       state_d = DATA;
                end
            end
            DATA: begin
                if (consume && byte_last && word_last) state_d = CSUM;
            end
            CSUM: begin
                if (consume) state_d = (rx_data == sum_q) ? DONE : ERROR;
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = ERROR;
        if (reload)  state_d = IDLE;
    end

    // Datapath next values: length capture, word assembly, sum, write strobe.
    always_comb begin
        len_d          = len_q;
        sum_d          = sum_q;
        byte_idx_d     = byte_idx_q;
        word_idx_d     = word_idx_q;
        asm_d          = asm_q;
        words_loaded_d = words_loaded_q;
        prog_addr_d    = prog_addr_q;
        prog_wdata_d   = prog_wdata_q;
        prog_we_d      = 1'b0;
        done_d         = (state_d == DONE);
        err_d          = (state_d == ERROR);

        idle_cnt_d = '0;
        if (in_frame(state_q) && in_frame(state_d) && !consume) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (consume) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == MAGIC) begin
                        len_d          = '0;
                        sum_d          = '0;
                        byte_idx_d     = '0;
                        word_idx_d     = '0;
                        words_loaded_d = '0;
                    end
                end
                LEN0: len_d[7:0]  = rx_data;
                LEN1: len_d[15:8] = rx_data;
                DATA: begin
                    sum_d      = sum_q + rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            prog_we_d      = 1'b1;
                            prog_wdata_d   = {rx_data, asm_q};
                            prog_addr_d    = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                            word_idx_d     = word_idx_q + 16'd1;
                            words_loaded_d = words_loaded_q + 16'd1;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        if (reload) begin
            len_d          = '0;
            sum_d          = '0;
            byte_idx_d     = '0;
            word_idx_d     = '0;
            words_loaded_d = '0;
            idle_cnt_d     = '0;
            prog_we_d      = 1'b0;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q          <= '0;
            sum_q          <= '0;
            byte_idx_q     <= '0;
            word_idx_q     <= '0;
            asm_q          <= '0;
            idle_cnt_q     <= '0;
            words_loaded_q <= '0;
            prog_addr_q    <= '0;
            prog_wdata_q   <= '0;
            prog_we_q      <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            len_q          <= len_d;
            sum_q          <= sum_d;
            byte_idx_q     <= byte_idx_d;
            word_idx_q     <= word_idx_d;
            asm_q          <= asm_d;
            idle_cnt_q     <= idle_cnt_d;
            words_loaded_q <= words_loaded_d;
            prog_addr_q    <= prog_addr_d;
            prog_wdata_q   <= prog_wdata_d;
            prog_we_q      <= prog_we_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    // Outputs: ready while a frame can still be accepted, held low in reset.
    always_comb begin
        rx_ready = rst_n && ((state_q == IDLE) || in_frame(state_q));
    end

    assign prog_addr         = prog_addr_q;
    assign prog_wdata        = prog_wdata_q;
    assign prog_we           = prog_we_q;
    assign prog_loading_done = done_q;
    assign load_error        = err_q;
    assign words_loaded      = words_loaded_q;

endmodule
